// File: rtl/switchbox_cfg_loader.sv
// Bit-serial route-configuration loader: shadow-loads addressed route entries, commits atomically.
// Build option: define CFG_PARITY_EN for a 12th even-parity bit per frame.
module switchbox_cfg_loader #(
  parameter int unsigned N_TB  = 5,
  parameter int unsigned N_LR  = 4,
  parameter int unsigned ENT_W = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start,
  input  logic                                 cfg_bit,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err,
  output logic [(2*N_TB+2*N_LR)*ENT_W-1:0]     route_active
);

  localparam int unsigned NumEnt = 2 * N_TB + 2 * N_LR;
  localparam int unsigned RouteW = NumEnt * ENT_W;
  localparam int unsigned AddrW  = 5;
`ifdef CFG_PARITY_EN
  localparam int unsigned FrameW = AddrW + ENT_W + 1;
`else
  localparam int unsigned FrameW = AddrW + ENT_W;
`endif
  localparam logic [3:0]       LastBit = 4'(FrameW - 1);
  localparam logic [AddrW-1:0] AddrEnd = 5'd31;

  typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [RouteW-1:0]   shadow_q, shadow_d;
  logic [RouteW-1:0]   active_q, active_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic [FrameW-1:0]   full;
  logic [AddrW-1:0]    addr;
  logic [ENT_W-1:0]    data;
  logic                parity_ok;

  // Side codes: 1 top, 2 right, 3 bottom, 4 left. Address blocks: top, bottom, left, right.
  function automatic logic entry_legal(input logic [AddrW-1:0] a_in, input logic [ENT_W-1:0] ent);
    logic [2:0]  side;
    int unsigned idx, a, own_side, own_idx;
    logic        ok;
    side = ent[2:0];
    idx  = 32'(ent[5:3]);
    a    = 32'(a_in);
    if (a < N_TB) begin
      own_side = 1; own_idx = a;
    end else if (a < 2 * N_TB) begin
      own_side = 3; own_idx = a - N_TB;
    end else if (a < 2 * N_TB + N_LR) begin
      own_side = 4; own_idx = a - 2 * N_TB;
    end else begin
      own_side = 2; own_idx = a - 2 * N_TB - N_LR;
    end
    case (side)
      3'd0:       ok = 1'b1;
      3'd1, 3'd3: ok = (idx < N_TB);
      3'd2, 3'd4: ok = (idx < N_LR);
      default:    ok = 1'b0;
    endcase
    if (side != 3'd0 && 32'(side) == own_side && idx == own_idx) ok = 1'b0;
    return ok;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    done_d   = 1'b0;

    full = {frame_q[FrameW-2:0], cfg_bit};
    addr = full[FrameW-1 -: AddrW];
    data = full[FrameW-AddrW-1 -: ENT_W];
`ifdef CFG_PARITY_EN
    parity_ok = ~^full;
`else
    parity_ok = 1'b1;
`endif

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          shadow_d = active_q;
          err_d    = 1'b0;
          cnt_d    = 4'd0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (cfg_valid) begin
          frame_d = full;
          if (cnt_q == LastBit) begin
            cnt_d = 4'd0;
            // A frame with bad parity is dropped whole, even an end marker.
            if (!parity_ok) begin
              err_d = 1'b1;
            end else if (addr == AddrEnd) begin
              state_d = StCommit;
            end else if (32'(addr) < NumEnt && entry_legal(addr, data)) begin
              for (int unsigned k = 0; k < NumEnt; k++) begin
                if (addr == 5'(k)) shadow_d[k*ENT_W +: ENT_W] = data;
              end
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StCommit: begin
        if (!err_q) active_d = shadow_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      frame_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready    = (state_q == StLoad);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign route_active = active_q;

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Directed bench for switchbox_cfg_loader; expected route image kept by hand in exp_route.
module tb_switchbox_cfg_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_start = 1'b0;
  logic         cfg_bit = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready, busy, done, err;
  logic [107:0] route_active;

  logic [107:0] exp_route = '0;
  int           checks = 0;
  int           failures = 0;
  int           gap_max = 0;

  switchbox_cfg_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_bit      (cfg_bit),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .route_active (route_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      cfg_valid = 1'b0;
      cfg_bit   = ~b;
      tick();
      checks++;
      if (cfg_ready !== 1'b1) begin
        failures++;
        $display("FAIL gap_ready got=%b exp=1", cfg_ready);
      end
    end
    cfg_bit   = b;
    cfg_valid = 1'b1;
    tick();
  endtask

  task automatic send_frame(input logic [4:0] a, input logic [5:0] d, input logic flip_par);
    logic [11:0] f;
    int          n;
`ifdef CFG_PARITY_EN
    f = {a, d, (^{a, d}) ^ flip_par};
    n = 12;
`else
    f = {flip_par, a, d};
    n = 11;
`endif
    for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
    cfg_valid = 1'b0;
  endtask

  task automatic start_session();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL start busy/ready got=%b%b exp=11", busy, cfg_ready);
    end
  endtask

  // Sends the end marker and checks the COMMIT cycle and the done pulse.
  task automatic end_session(input string name, input logic start_in_commit);
    send_frame(5'd31, 6'd0, 1'b0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s commit done/busy/ready got=%b%b%b exp=010", name, done, busy, cfg_ready);
    end
    cfg_start = start_in_commit;
    tick();
    cfg_start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse done/busy got=%b%b exp=10", name, done, busy);
    end
    checks++;
    if (route_active !== exp_route) begin
      failures++;
      $display("FAIL %s route got=%h exp=%h", name, route_active, exp_route);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done done/busy got=%b%b exp=00", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (route_active !== '0 || cfg_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        done !== 1'b0) begin
      failures++;
      $display("FAIL reset route=%h ready=%b busy=%b err=%b done=%b exp all 0",
               route_active, cfg_ready, busy, err, done);
    end
    rst = 1'b0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_valid busy/ready got=%b%b exp=00", busy, cfg_ready);
    end
  endtask

  task automatic test_basic();
    start_session();
    send_frame(5'd0, 6'h14, 1'b0);
    exp_route[5:0] = 6'h14;
    end_session("basic", 1'b0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL basic_err got=%b exp=0", err);
    end
  endtask

  task automatic test_retain();
    start_session();
    send_frame(5'd15, 6'h1A, 1'b0);
    exp_route[95:90] = 6'h1A;
    end_session("retain_a", 1'b0);
    start_session();
    send_frame(5'd0, 6'h00, 1'b0);
    exp_route[5:0] = 6'h00;
    end_session("retain_b", 1'b0);
    checks++;
    if (route_active[95:90] !== 6'h1A) begin
      failures++;
      $display("FAIL retain_entry15 got=%h exp=1a", route_active[95:90]);
    end
  endtask

  task automatic test_legal_boundaries();
    start_session();
    send_frame(5'd9, 6'h21, 1'b0);   // bottom[4] <- top[4]
    send_frame(5'd12, 6'h1C, 1'b0);  // left[2] <- left[3]
    send_frame(5'd17, 6'h38, 1'b0);  // right[3] off, index ignored
    send_frame(5'd4, 6'h0B, 1'b0);   // top[4] <- bottom[1]
    send_frame(5'd13, 6'h23, 1'b0);  // left[3] <- bottom[4]
    exp_route[59:54]   = 6'h21;
    exp_route[77:72]   = 6'h1C;
    exp_route[107:102] = 6'h38;
    exp_route[29:24]   = 6'h0B;
    exp_route[83:78]   = 6'h23;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL legal_err got=%b exp=0", err);
    end
    end_session("legal", 1'b0);
  endtask

  task automatic test_illegal();
    logic [4:0] ia [8] = '{5'd2, 5'd1, 5'd3, 5'd10, 5'd14, 5'd0, 5'd18, 5'd30};
    logic [5:0] id [8] = '{6'h11, 6'h05, 6'h07, 6'h22, 6'h24, 6'h29, 6'h00, 6'h00};
    for (int i = 0; i < 8; i++) begin
      start_session();
      send_frame(ia[i], id[i], 1'b0);
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL illegal_%0d err got=%b exp=1", i, err);
      end
      end_session("illegal", 1'b0);
    end
  endtask

  task automatic test_errors();
    start_session();
    send_frame(5'd20, 6'h00, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_addr20 got=%b exp=1", err);
    end
    send_frame(5'd5, 6'h2B, 1'b0);
    end_session("err_session", 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    start_session();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared got=%b exp=0", err);
    end
    end_session("err_clear", 1'b0);
  endtask

  task automatic test_gaps();
    gap_max = 3;
    start_session();
    send_frame(5'd1, 6'h1C, 1'b0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL midload_start busy/ready got=%b%b exp=11", busy, cfg_ready);
    end
    send_frame(5'd16, 6'h09, 1'b0);
    exp_route[11:6]  = 6'h1C;
    exp_route[101:96] = 6'h09;
    gap_max = 0;
    end_session("gaps", 1'b1);
  endtask

  task automatic test_reset_mid();
    start_session();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    cfg_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_route = '0;
    checks++;
    if (route_active !== '0 || cfg_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid route=%h ready=%b busy=%b err=%b done=%b exp all 0",
               route_active, cfg_ready, busy, err, done);
    end
    start_session();
    send_frame(5'd7, 6'h0A, 1'b0);
    exp_route[47:42] = 6'h0A;
    end_session("after_reset", 1'b0);
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    start_session();
    send_frame(5'd0, 6'h21, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL parity_err got=%b exp=1", err);
    end
    send_frame(5'd31, 6'h00, 1'b1);
    checks++;
    if (busy !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL parity_marker busy/ready got=%b%b exp=11", busy, cfg_ready);
    end
    end_session("parity", 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_retain();
    test_legal_boundaries();
    test_illegal();
    test_errors();
    test_gaps();
    test_reset_mid();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
